// File: rtl/riscv_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// riscv_lsu_ctrl
//
// Load/store sequencer for the MEM stage. Accepts one load or store from the
// pipeline, checks its natural alignment, runs it over a req/gnt/rvalid data
// memory port and stalls the pipeline until the access completes. Returned
// load data is registered together with funct3 and the full byte address for
// the downstream memory-extension unit.
//
// Memory port handshake: o_mem_req is held high, with mem_addr/we/wdata/strb
// stable, until the cycle in which i_mem_gnt is sampled high; that cycle
// completes the request. For loads the data is taken in the first later cycle
// in which i_mem_rvalid is high; rvalid is not expected before gnt.
//
// Ports:
//   i_riscv_lsuctrl_clk / _rst       clock (rising) / async active-high reset
//   i_riscv_lsuctrl_memread/memwrite load / store request (both = store)
//   i_riscv_lsuctrl_funct3           size[1:0] B/H/W/D, bit2 unsigned (loads)
//   i_riscv_lsuctrl_addr / _wdata    byte address / right-aligned store data
//   i_riscv_lsuctrl_flush            kill the in-flight instruction
//   o_riscv_lsuctrl_stall            hold the pipeline
//   o_riscv_lsuctrl_misalign         misaligned request (combinational)
//   o_riscv_lsuctrl_fault            timeout fault, one-cycle pulse in DONE
//   o_riscv_lsuctrl_mem_*            data memory request port
//   i_riscv_lsuctrl_mem_gnt/rvalid/rdata  data memory responses
//   o_riscv_lsuctrl_memext_sel/addr/data  captured funct3/address/rdata
//   o_riscv_lsuctrl_ldvalid          load result valid, one-cycle pulse
//   o_riscv_lsuctrl_state            FSM state: 0 IDLE, 1 REQ, 2 WAIT, 3 DONE
// ---------------------------------------------------------------------------
module riscv_lsu_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_riscv_lsuctrl_clk,
    input  logic        i_riscv_lsuctrl_rst,
    input  logic        i_riscv_lsuctrl_memread,
    input  logic        i_riscv_lsuctrl_memwrite,
    input  logic [2:0]  i_riscv_lsuctrl_funct3,
    input  logic [63:0] i_riscv_lsuctrl_addr,
    input  logic [63:0] i_riscv_lsuctrl_wdata,
    input  logic        i_riscv_lsuctrl_flush,
    output logic        o_riscv_lsuctrl_stall,
    output logic        o_riscv_lsuctrl_misalign,
    output logic        o_riscv_lsuctrl_fault,
    output logic        o_riscv_lsuctrl_mem_req,
    output logic        o_riscv_lsuctrl_mem_we,
    output logic [63:0] o_riscv_lsuctrl_mem_addr,
    output logic [63:0] o_riscv_lsuctrl_mem_wdata,
    output logic [7:0]  o_riscv_lsuctrl_mem_strb,
    input  logic        i_riscv_lsuctrl_mem_gnt,
    input  logic        i_riscv_lsuctrl_mem_rvalid,
    input  logic [63:0] i_riscv_lsuctrl_mem_rdata,
    output logic [2:0]  o_riscv_lsuctrl_memext_sel,
    output logic [63:0] o_riscv_lsuctrl_memext_addr,
    output logic [63:0] o_riscv_lsuctrl_memext_data,
    output logic        o_riscv_lsuctrl_ldvalid,
    output logic [1:0]  o_riscv_lsuctrl_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic        r_kill;
    logic [7:0]  r_cnt;
    logic        r_fault;
    logic        r_ldvalid;
    logic [2:0]  r_memext_sel;
    logic [63:0] r_memext_addr;
    logic [63:0] r_memext_data;

    logic        w_req;
    logic        w_misaligned;
    logic        w_idle;
    logic        w_in_req;
    logic        w_accept;
    logic        w_timeout;
    logic [7:0]  w_strb;
    logic [63:0] w_wdata_rep;

    assign w_req    = i_riscv_lsuctrl_memread | i_riscv_lsuctrl_memwrite;
    assign w_idle   = (r_state == S_IDLE);
    assign w_in_req = (r_state == S_REQ);

    always_comb begin
        w_misaligned = 1'b0;
        case (i_riscv_lsuctrl_funct3[1:0])
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = i_riscv_lsuctrl_addr[0];
            2'b10:   w_misaligned = |i_riscv_lsuctrl_addr[1:0];
            default: w_misaligned = |i_riscv_lsuctrl_addr[2:0];
        endcase
    end

    assign w_accept = w_idle & w_req & ~i_riscv_lsuctrl_flush & ~w_misaligned;

    // Compared with >= so that a gnt taken on the very last counted cycle
    // still leaves the WAIT phase bounded instead of waiting for the 8-bit
    // counter to wrap.
    assign w_timeout = (r_cnt >= TO_LAST);

    // Lane placement from the captured size and address.
    always_comb begin
        w_strb      = 8'hFF;
        w_wdata_rep = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_strb      = 8'b1 << r_addr[2:0];
                w_wdata_rep = {8{r_wdata[7:0]}};
            end
            2'b01: begin
                w_strb      = 8'b11 << {r_addr[2:1], 1'b0};
                w_wdata_rep = {4{r_wdata[15:0]}};
            end
            2'b10: begin
                w_strb      = 8'h0F << {r_addr[2], 2'b00};
                w_wdata_rep = {2{r_wdata[31:0]}};
            end
            default: begin
                w_strb      = 8'hFF;
                w_wdata_rep = r_wdata;
            end
        endcase
        if (!r_we) begin
            w_strb = 8'hFF;
        end
    end

    assign o_riscv_lsuctrl_stall     = w_accept | (r_state == S_REQ) | (r_state == S_WAIT);
    assign o_riscv_lsuctrl_misalign  = w_idle & w_req & ~i_riscv_lsuctrl_flush & w_misaligned;
    assign o_riscv_lsuctrl_mem_req   = w_in_req;
    assign o_riscv_lsuctrl_mem_we    = w_in_req & r_we;
    assign o_riscv_lsuctrl_mem_addr  = w_in_req ? {r_addr[63:3], 3'b000} : 64'd0;
    assign o_riscv_lsuctrl_mem_wdata = w_in_req ? w_wdata_rep : 64'd0;
    assign o_riscv_lsuctrl_mem_strb  = w_in_req ? w_strb : 8'd0;

    assign o_riscv_lsuctrl_fault       = r_fault;
    assign o_riscv_lsuctrl_ldvalid     = r_ldvalid;
    assign o_riscv_lsuctrl_memext_sel  = r_memext_sel;
    assign o_riscv_lsuctrl_memext_addr = r_memext_addr;
    assign o_riscv_lsuctrl_memext_data = r_memext_data;
    assign o_riscv_lsuctrl_state       = r_state;

    always_ff @(posedge i_riscv_lsuctrl_clk or posedge i_riscv_lsuctrl_rst) begin
        if (i_riscv_lsuctrl_rst) begin
            r_state       <= S_IDLE;
            r_we          <= 1'b0;
            r_funct3      <= 3'd0;
            r_addr        <= 64'd0;
            r_wdata       <= 64'd0;
            r_kill        <= 1'b0;
            r_cnt         <= 8'd0;
            r_fault       <= 1'b0;
            r_ldvalid     <= 1'b0;
            r_memext_sel  <= 3'd0;
            r_memext_addr <= 64'd0;
            r_memext_data <= 64'd0;
        end else begin
            // fault and ldvalid are only ever high during the DONE cycle.
            r_fault   <= 1'b0;
            r_ldvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we     <= i_riscv_lsuctrl_memwrite;
                        r_funct3 <= i_riscv_lsuctrl_funct3;
                        r_addr   <= i_riscv_lsuctrl_addr;
                        r_wdata  <= i_riscv_lsuctrl_wdata;
                        r_kill   <= 1'b0;
                        r_cnt    <= 8'd0;
                        if (!i_riscv_lsuctrl_memwrite) begin
                            r_memext_sel  <= i_riscv_lsuctrl_funct3;
                            r_memext_addr <= i_riscv_lsuctrl_addr;
                        end
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (i_riscv_lsuctrl_mem_gnt) begin
                        // Request already accepted by memory: it must run to
                        // completion, only its result is discarded.
                        if (i_riscv_lsuctrl_flush) begin
                            r_kill <= 1'b1;
                        end
                        r_state <= r_we ? S_DONE : S_WAIT;
                    end else if (i_riscv_lsuctrl_flush) begin
                        r_state <= S_IDLE;
                    end else if (w_timeout) begin
                        r_fault <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (i_riscv_lsuctrl_flush) begin
                        r_kill <= 1'b1;
                    end
                    if (i_riscv_lsuctrl_mem_rvalid) begin
                        r_memext_data <= i_riscv_lsuctrl_mem_rdata;
                        r_ldvalid     <= ~(r_kill | i_riscv_lsuctrl_flush);
                        r_state       <= S_DONE;
                    end else if (w_timeout) begin
                        r_fault <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_kill  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
// Self-checking bench for riscv_lsu_ctrl. The bench plays both the pipeline
// and the data memory; expected values come from a reference model that
// works in whole transactions (cycle counts, lane arithmetic).
module tb_riscv_lsu_ctrl;

    localparam int T = 4;

    logic        clk;
    logic        rst;
    logic        i_memread;
    logic        i_memwrite;
    logic [2:0]  i_funct3;
    logic [63:0] i_addr;
    logic [63:0] i_wdata;
    logic        i_flush;
    logic        o_stall;
    logic        o_misalign;
    logic        o_fault;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [63:0] o_mem_addr;
    logic [63:0] o_mem_wdata;
    logic [7:0]  o_mem_strb;
    logic        i_gnt;
    logic        i_rvalid;
    logic [63:0] i_rdata;
    logic [2:0]  o_sel;
    logic [63:0] o_eaddr;
    logic [63:0] o_edata;
    logic        o_ldvalid;
    logic [1:0]  o_state;

    int n_checks;
    int n_err;

    // Reference state of the extension outputs.
    logic [2:0]  exp_sel;
    logic [63:0] exp_eaddr;
    logic [63:0] exp_edata;

    riscv_lsu_ctrl #(.TIMEOUT(T)) dut (
        .i_riscv_lsuctrl_clk         (clk),
        .i_riscv_lsuctrl_rst         (rst),
        .i_riscv_lsuctrl_memread     (i_memread),
        .i_riscv_lsuctrl_memwrite    (i_memwrite),
        .i_riscv_lsuctrl_funct3      (i_funct3),
        .i_riscv_lsuctrl_addr        (i_addr),
        .i_riscv_lsuctrl_wdata       (i_wdata),
        .i_riscv_lsuctrl_flush       (i_flush),
        .o_riscv_lsuctrl_stall       (o_stall),
        .o_riscv_lsuctrl_misalign    (o_misalign),
        .o_riscv_lsuctrl_fault       (o_fault),
        .o_riscv_lsuctrl_mem_req     (o_mem_req),
        .o_riscv_lsuctrl_mem_we      (o_mem_we),
        .o_riscv_lsuctrl_mem_addr    (o_mem_addr),
        .o_riscv_lsuctrl_mem_wdata   (o_mem_wdata),
        .o_riscv_lsuctrl_mem_strb    (o_mem_strb),
        .i_riscv_lsuctrl_mem_gnt     (i_gnt),
        .i_riscv_lsuctrl_mem_rvalid  (i_rvalid),
        .i_riscv_lsuctrl_mem_rdata   (i_rdata),
        .o_riscv_lsuctrl_memext_sel  (o_sel),
        .o_riscv_lsuctrl_memext_addr (o_eaddr),
        .o_riscv_lsuctrl_memext_data (o_edata),
        .o_riscv_lsuctrl_ldvalid     (o_ldvalid),
        .o_riscv_lsuctrl_state       (o_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: byte enables of an access, from size and byte offset.
    function automatic logic [7:0] exp_strb(input bit ld, input logic [2:0] f3, input logic [63:0] a);
        int nb;
        nb = 1 << f3[1:0];
        if (ld) return 8'hFF;
        return 8'(((1 << nb) - 1) << int'(a[2:0]));
    endfunction

    // Model: every byte lane i carries store byte (i mod size).
    function automatic logic [63:0] exp_wdata(input logic [2:0] f3, input logic [63:0] wd);
        int nb;
        logic [63:0] r;
        nb = 1 << f3[1:0];
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i*8 +: 8] = wd[(i % nb)*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic check_ext(input string tag);
        chk({tag, "_sel"},   64'(o_sel),   64'(exp_sel));
        chk({tag, "_eaddr"}, o_eaddr,      exp_eaddr);
        chk({tag, "_edata"}, o_edata,      exp_edata);
    endtask

    // One complete access. dg = REQ cycle index in which gnt is given,
    // dr = WAIT cycle index in which rvalid is given, flush_wait = flush in
    // the first WAIT cycle.
    task automatic run_access(input bit ld, input logic [2:0] f3, input logic [63:0] a,
                              input logic [63:0] wd, input logic [63:0] rd,
                              input int dg, input int dr, input bit flush_wait);
        int n_req;
        int n_wait;
        int jt;
        bit timed;
        bit killed;
        logic [7:0]  e_strb;
        logic [63:0] e_wdata;

        // Transaction-level model: a REQ/WAIT cycle carries count = cycles
        // since entering REQ; the access aborts once count reaches T-1
        // without its exit condition.
        timed  = (dg >= T);
        n_req  = timed ? T : dg + 1;
        n_wait = 0;
        killed = 1'b0;
        if (ld && !timed) begin
            jt = (T - 2 - dg > 0) ? T - 2 - dg : 0;
            if (dr <= jt) begin
                n_wait = dr + 1;
            end else begin
                n_wait = jt + 1;
                timed  = 1'b1;
            end
            killed = flush_wait;
        end
        e_strb  = exp_strb(ld, f3, a);
        e_wdata = exp_wdata(f3, wd);

        i_memread  = ld;
        i_memwrite = !ld;
        i_funct3   = f3;
        i_addr     = a;
        i_wdata    = wd;
        i_flush    = 1'b0;
        #3;
        chk("acc_stall", 64'(o_stall), 64'd1);
        chk("acc_misalign", 64'(o_misalign), 64'd0);
        chk("acc_req", 64'(o_mem_req), 64'd0);
        @(posedge clk); #1;
        // Scramble the pipeline inputs: the port must hold captured values.
        i_memread  = 1'b0;
        i_memwrite = 1'b0;
        i_addr     = rnd64();
        i_wdata    = rnd64();
        i_funct3   = 3'($urandom_range(0, 7));
        if (ld) begin
            exp_sel   = f3;
            exp_eaddr = a;
        end

        for (int k = 0; k < n_req; k++) begin
            i_gnt = (k == dg);
            #3;
            chk("req_state", 64'(o_state), 64'd1);
            chk("req_req", 64'(o_mem_req), 64'd1);
            chk("req_stall", 64'(o_stall), 64'd1);
            chk("req_we", 64'(o_mem_we), 64'(!ld));
            chk("req_addr", o_mem_addr, a & ~64'h7);
            chk("req_strb", 64'(o_mem_strb), 64'(e_strb));
            if (!ld) chk("req_wdata", o_mem_wdata, e_wdata);
            @(posedge clk); #1;
            i_gnt = 1'b0;
        end

        for (int j = 0; j < n_wait; j++) begin
            i_rvalid = (j == dr);
            i_rdata  = (j == dr) ? rd : rnd64();
            i_flush  = flush_wait && (j == 0);
            #3;
            chk("wait_state", 64'(o_state), 64'd2);
            chk("wait_req", 64'(o_mem_req), 64'd0);
            chk("wait_stall", 64'(o_stall), 64'd1);
            @(posedge clk); #1;
            if (j == dr) exp_edata = rd;
            i_rvalid = 1'b0;
            i_flush  = 1'b0;
        end

        #3;
        chk("done_state", 64'(o_state), 64'd3);
        chk("done_stall", 64'(o_stall), 64'd0);
        chk("done_req", 64'(o_mem_req), 64'd0);
        chk("done_fault", 64'(o_fault), 64'(timed));
        chk("done_ldvalid", 64'(o_ldvalid), 64'(ld && !timed && !killed));
        @(posedge clk); #1;
        #3;
        chk("post_state", 64'(o_state), 64'd0);
        chk("post_fault", 64'(o_fault), 64'd0);
        chk("post_ldvalid", 64'(o_ldvalid), 64'd0);
        check_ext("post");
        @(posedge clk); #1;
    endtask

    task automatic try_misaligned(input bit ld, input logic [2:0] f3, input logic [63:0] a);
        i_memread  = ld;
        i_memwrite = !ld;
        i_funct3   = f3;
        i_addr     = a;
        i_wdata    = rnd64();
        #3;
        chk("mis_flag", 64'(o_misalign), 64'd1);
        chk("mis_stall", 64'(o_stall), 64'd0);
        chk("mis_req", 64'(o_mem_req), 64'd0);
        @(posedge clk); #1;
        i_memread  = 1'b0;
        i_memwrite = 1'b0;
        #3;
        chk("mis_state", 64'(o_state), 64'd0);
        chk("mis_req2", 64'(o_mem_req), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int sz;
        int nb;
        logic [63:0] a;
        n_checks   = 0;
        n_err      = 0;
        exp_sel    = '0;
        exp_eaddr  = '0;
        exp_edata  = '0;
        rst        = 1'b1;
        i_memread  = 1'b0;
        i_memwrite = 1'b0;
        i_funct3   = '0;
        i_addr     = '0;
        i_wdata    = '0;
        i_flush    = 1'b0;
        i_gnt      = 1'b0;
        i_rvalid   = 1'b0;
        i_rdata    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 64'(o_state), 64'd0);
        chk("rst_stall", 64'(o_stall), 64'd0);
        chk("rst_req", 64'(o_mem_req), 64'd0);
        chk("rst_fault", 64'(o_fault), 64'd0);
        chk("rst_ldvalid", 64'(o_ldvalid), 64'd0);
        check_ext("rst");
        rst = 1'b0;
        @(posedge clk); #1;

        // lw with immediate gnt and rvalid
        run_access(1'b1, 3'b010, 64'h1004, 64'h0, 64'h80000001_00000000, 0, 0, 1'b0);
        // sb with gnt in the third REQ cycle
        run_access(1'b0, 3'b000, 64'h2003, 64'hAB, 64'h0, 2, 0, 1'b0);
        chk("sb_wdata_const", exp_wdata(3'b000, 64'hAB), 64'hABABABABABABABAB);
        // misaligned lh and sd
        try_misaligned(1'b1, 3'b001, 64'h3001);
        try_misaligned(1'b0, 3'b011, 64'h3004);
        // lw that never gets gnt
        run_access(1'b1, 3'b010, 64'h4000, 64'h0, 64'h0, 100, 0, 1'b0);
        // ld flushed in WAIT, rvalid two cycles later
        run_access(1'b1, 3'b011, 64'h6008, 64'h0, 64'hDEADBEEF_CAFEF00D, 0, 2, 1'b1);

        // flush in REQ without gnt aborts the access
        i_memread = 1'b1;
        i_funct3  = 3'b010;
        i_addr    = 64'h7000;
        #3;
        chk("fl_accept_stall", 64'(o_stall), 64'd1);
        @(posedge clk); #1;
        i_memread = 1'b0;
        exp_sel   = 3'b010;
        exp_eaddr = 64'h7000;
        i_flush   = 1'b1;
        #3;
        chk("fl_req", 64'(o_mem_req), 64'd1);
        @(posedge clk); #1;
        i_flush = 1'b0;
        #3;
        chk("fl_req_drop", 64'(o_mem_req), 64'd0);
        chk("fl_state", 64'(o_state), 64'd0);
        chk("fl_stall", 64'(o_stall), 64'd0);
        chk("fl_ldvalid", 64'(o_ldvalid), 64'd0);
        check_ext("fl");
        @(posedge clk); #1;

        // reset while waiting for read data
        i_memread = 1'b1;
        i_funct3  = 3'b011;
        i_addr    = 64'h8000;
        @(posedge clk); #1;
        i_memread = 1'b0;
        i_gnt     = 1'b1;
        @(posedge clk); #1;
        i_gnt = 1'b0;
        #3;
        chk("mid_wait_state", 64'(o_state), 64'd2);
        rst = 1'b1;
        #1;
        exp_sel   = '0;
        exp_eaddr = '0;
        exp_edata = '0;
        chk("arst_state", 64'(o_state), 64'd0);
        chk("arst_stall", 64'(o_stall), 64'd0);
        chk("arst_req", 64'(o_mem_req), 64'd0);
        chk("arst_addr", o_mem_addr, 64'd0);
        chk("arst_strb", 64'(o_mem_strb), 64'd0);
        chk("arst_fault", 64'(o_fault), 64'd0);
        chk("arst_ldvalid", 64'(o_ldvalid), 64'd0);
        check_ext("arst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_idle", 64'(o_state), 64'd0);
        run_access(1'b0, 3'b010, 64'h5004, 64'h12345678, 64'h0, 0, 0, 1'b0);
        chk("sw_strb_const", 64'(exp_strb(1'b0, 3'b010, 64'h5004)), 64'hF0);

        // randomized mix
        for (int it = 0; it < 40; it++) begin
            sz = $urandom_range(0, 3);
            nb = 1 << sz;
            a  = rnd64();
            if (sz != 0 && $urandom_range(0, 4) == 0) begin
                a = (a & ~64'(nb - 1)) | 64'($urandom_range(1, nb - 1));
                try_misaligned(1'($urandom_range(0, 1)), 3'(sz), a);
            end else begin
                a = a & ~64'(nb - 1);
                if ($urandom_range(0, 1) == 1) begin
                    run_access(1'b1, {1'($urandom_range(0, 1)), 2'(sz)}, a, rnd64(), rnd64(),
                               $urandom_range(0, 4), $urandom_range(0, 3),
                               $urandom_range(0, 4) == 0);
                end else begin
                    run_access(1'b0, 3'(sz), a, rnd64(), rnd64(),
                               $urandom_range(0, 4), 0, 1'b0);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
